// File: rtl/vec_unpacker_pkg.sv
// vec_unpacker_pkg: occupancy states and default lane geometry shared with the FIFO side
package vec_unpacker_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam int DEF_LANE_WIDTH = 32;
    localparam int DEF_LANES = 6;
endpackage

// File: rtl/vec_unpacker_lane_mux.sv
// lane_mux: selects lane idx out of a packed multi-lane vector
module lane_mux #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES = 6,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic [LANE_WIDTH*LANES-1:0] vec,
    input  logic [IDX_W-1:0]            idx,
    output logic [LANE_WIDTH-1:0]       lane
);
    always_comb begin
        lane = '0;
        for (int k = 0; k < LANES; k++)
            if (idx == IDX_W'(k)) lane = vec[k*LANE_WIDTH +: LANE_WIDTH];
    end
endmodule

// File: rtl/vec_unpacker.sv
// vec_unpacker: splits wide FIFO vectors into a lane stream, double-buffered so vectors leave back-to-back
module vec_unpacker
    import vec_unpacker_pkg::*;
#(
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANE_WIDTH*LANES-1:0] fifo_dout,
    input  logic                        fifo_empty,
    input  logic                        fifo_out_valid,
    output logic                        fifo_request,
    output logic [LANE_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic [CNT_WIDTH-1:0]        vec_count,
    output logic                        busy
);
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    state_t state, state_nx;
    logic [LANE_WIDTH*LANES-1:0] cur, nxt;
    logic [IDX_W-1:0] idx;
    logic xfer, fin, cap, empty_unused;

    assign cap = fifo_out_valid;
    assign xfer = m_valid && m_ready;
    assign fin = xfer && m_last;
    // The FIFO's own strobe already qualifies captures; the empty flag is informational only.
    assign empty_unused = fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = (state == EMPTY) ? (cap ? ONE : EMPTY)
                 : (state == ONE)   ? (fin ? (cap ? ONE : EMPTY) : (cap ? TWO : ONE))
                 :                    (fin ? ONE : TWO);
    end

    always_comb begin
        m_valid = state != EMPTY;
        busy = state != EMPTY;
        fifo_request = state != TWO;
        m_last = (state != EMPTY) && (idx == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            vec_count <= '0;
        end else begin
            if (xfer) idx <= fin ? '0 : idx + 1'b1;
            if (cap) vec_count <= vec_count + 1'b1;
        end
    end

    // Slot storage is deliberately unreset; state alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (cap && (state == EMPTY || (state == ONE && fin))) cur <= fifo_dout;
        else if (state == TWO && fin) cur <= nxt;
        if (cap && state == ONE && !fin) nxt <= fifo_dout;
    end

    lane_mux #(.LANE_WIDTH(LANE_WIDTH), .LANES(LANES)) u_mux (
        .vec(cur),
        .idx(idx),
        .lane(m_data)
    );
endmodule

// File: tb/tb_vec_unpacker.sv
// tb_vec_unpacker: directed vectors through a FIFO model, scoreboard monitor checks lane order and stalls
module tb_vec_unpacker;
    localparam int LW = 32;
    localparam int NL = 6;
    localparam int CW = 8;

    logic clk = 0, rst = 1;
    logic [LW*NL-1:0] fifo_dout;
    logic fifo_empty, fifo_out_valid, fifo_request;
    logic [LW-1:0] m_data;
    logic m_valid, m_ready, m_last, busy;
    logic [CW-1:0] vec_count;

    int checks = 0, errors = 0;
    logic [LW*NL-1:0] fifo_q[$];
    logic [LW:0] exp_q[$];

    vec_unpacker #(.LANE_WIDTH(LW), .LANES(NL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_out_valid(fifo_out_valid), .fifo_request(fifo_request),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_vec(input logic [LW-1:0] base);
        logic [LW*NL-1:0] v;
        for (int k = 0; k < NL; k++) begin
            v[k*LW +: LW] = base + LW'(k);
            exp_q.push_back({k == NL - 1, base + LW'(k)});
        end
        fifo_q.push_back(v);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: %0d lanes left, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_lane(input logic [LW-1:0] val, input int limit);
        int n = 0;
        while (!(m_valid && m_data == val) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_lane: lane %0h never seen", val);
        end
    endtask

    // FIFO model: presents head vector whenever the DUT requests and data is queued
    initial begin
        fifo_out_valid = 0;
        fifo_dout = '0;
        fifo_empty = 1;
        forever begin
            @(posedge clk);
            if (fifo_out_valid && !rst) void'(fifo_q.pop_front());
            #1;
            fifo_empty = fifo_q.size() == 0;
            fifo_out_valid = fifo_request && !fifo_empty;
            fifo_dout = fifo_empty ? '0 : fifo_q[0];
        end
    end

    // Monitor: pops expected lane on each transfer and checks stall stability
    initial begin
        logic prev_stall = 0;
        logic [LW:0] prev = '0, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    checks++;
                    if (!m_valid || {m_last, m_data} !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b %0h, expected v=1 %0h", m_valid, {m_last, m_data}, prev);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_lane: got %0h, expected no output", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            errors++;
                            $display("FAIL lane: got last=%0b data=%0h, expected last=%0b data=%0h", m_last, m_data, e[LW], e[LW-1:0]);
                        end
                    end
                end
            end
            prev_stall = !rst && m_valid && !m_ready;
            prev = {m_last, m_data};
        end
    end

    initial begin
        logic saw_low;
        logic [7:0] pat;
        m_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fifo_request", 64'(fifo_request), 64'd1);
        check("rst_vec_count", 64'(vec_count), 64'd0);
        rst = 0;
        m_ready = 1;

        push_vec(32'h10);
        wait_drain(100);
        check("single_vec_count", 64'(vec_count), 64'd1);
        check("single_idle_valid", 64'(m_valid), 64'd0);

        push_vec(32'h20);
        push_vec(32'h30);
        push_vec(32'h40);
        @(negedge clk);
        wait_lane(32'h20, 20);
        saw_low = 0;
        for (int i = 0; i < 3 * NL; i++) begin
            check("burst_no_bubble", 64'(m_valid), 64'd1);
            saw_low = saw_low | !fifo_request;
            @(negedge clk);
        end
        check("burst_prefetch_req_low", 64'(saw_low), 64'd1);
        wait_drain(100);
        check("burst_vec_count", 64'(vec_count), 64'd4);

        push_vec(32'h50);
        wait_lane(32'h50, 20);
        pat = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            m_ready = pat[i];
        end
        @(posedge clk);
        #1;
        m_ready = 1;
        wait_drain(100);
        check("stall_vec_count", 64'(vec_count), 64'd5);

        push_vec(32'h60);
        wait_lane(32'h64, 20);
        check("one_before_final_req", 64'(fifo_request), 64'd1);
        push_vec(32'h70);
        @(negedge clk);
        check("final_lane_last", 64'(m_last), 64'd1);
        @(negedge clk);
        check("coincide_lane0", 64'(m_data), 64'h70);
        check("coincide_valid", 64'(m_valid), 64'd1);
        check("coincide_state_one_req", 64'(fifo_request), 64'd1);
        wait_drain(100);
        check("coincide_vec_count", 64'(vec_count), 64'd7);

        push_vec(32'h80);
        push_vec(32'h90);
        wait_lane(32'h82, 20);
        check("two_req_low", 64'(fifo_request), 64'd0);
        #1;
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_vec_count", 64'(vec_count), 64'd0);
        check("midrst_fifo_request", 64'(fifo_request), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        push_vec(32'hA0);
        wait_drain(100);
        check("post_rst_vec_count", 64'(vec_count), 64'd1);

        for (int i = 1; i < 256; i++) push_vec(32'h1000 + 32'(i * 16));
        wait_drain(255 * NL + 200);
        check("wrap_vec_count", 64'(vec_count), 64'd0);
        check("wrap_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
